// File: rtl/mmio_bus_fabric.sv
// Registered, handshaked MMIO interconnect: decodes the CPU data port onto NUM_SLAVES regions
// with per-slave wait states, a bounded access timeout and decode-error responses.
module mmio_bus_fabric #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_m_req,
  input  logic                         i_m_write,
  input  logic [ADDR_W-1:0]            i_m_addr,
  input  logic [3:0]                   i_m_width,
  input  logic [DATA_W-1:0]            i_m_wdata,
  output logic [DATA_W-1:0]            o_m_rdata,
  output logic                         o_m_ready,
  output logic                         o_m_err,
  output logic [NUM_SLAVES-1:0]        o_s_sel,
  output logic                         o_s_write,
  output logic [ADDR_W-1:0]            o_s_addr,
  output logic [3:0]                   o_s_width,
  output logic [DATA_W-1:0]            o_s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_s_rdata,
  input  logic [NUM_SLAVES-1:0]        i_s_ready
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [NUM_SLAVES-1:0] ONE_HOT_BASE = NUM_SLAVES'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SEL_W-1:0]  r_idx;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_width;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [SEL_W-1:0]  w_req_idx;
  logic              w_req_ok;
  logic              w_slv_ready;
  logic [DATA_W-1:0] w_slv_rdata;
  logic              w_timeout;

  // Only the selected slave's ready/data are observed; the others are don't-care.
  assign w_req_idx   = i_m_addr[ADDR_W-1 -: SEL_W];
  assign w_req_ok    = (32'(w_req_idx) < 32'(NUM_SLAVES));
  assign w_slv_ready = i_s_ready[r_idx];
  assign w_slv_rdata = i_s_rdata[r_idx*DATA_W +: DATA_W];
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_m_req) begin
          w_next = w_req_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (w_slv_ready || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, wait counter and response capture; ready beats timeout in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_width <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_m_req) begin
            r_idx   <= w_req_idx;
            r_write <= i_m_write;
            r_addr  <= {{SEL_W{1'b0}}, i_m_addr[ADDR_W-SEL_W-1:0]};
            r_width <= i_m_width;
            r_wdata <= i_m_wdata;
            r_cnt   <= '0;
            if (!w_req_ok) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (w_slv_ready) begin
            r_err   <= 1'b0;
            r_rdata <= r_write ? '0 : w_slv_rdata;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_m_ready = (r_state == RESP);
    o_m_err   = (r_state == RESP) && r_err;
    o_m_rdata = r_rdata;
    o_s_sel   = '0;
    o_s_write = 1'b0;
    o_s_addr  = r_addr;
    o_s_width = r_width;
    o_s_wdata = r_wdata;
    if (r_state == ACCESS) begin
      o_s_sel   = ONE_HOT_BASE << r_idx;
      o_s_write = r_write;
    end
  end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: a 4-slave instance for the main scenarios and a 3-slave
// instance for the unmapped-region decode error.
module tb_mmio_bus_fabric;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req4, req3;
  logic        wr;
  logic [9:0]  addr;
  logic [3:0]  width;
  logic [31:0] wdata;

  logic [31:0]  rdata4;
  logic         ready4, err4, swrite4;
  logic [3:0]   sel4, swidth4;
  logic [9:0]   saddr4;
  logic [31:0]  swdata4;
  logic [127:0] srdata4;
  logic [3:0]   sready4;

  logic [31:0]  rdata3;
  logic         ready3, err3, swrite3;
  logic [2:0]   sel3;
  logic [3:0]   swidth3;
  logic [9:0]   saddr3;
  logic [31:0]  swdata3;
  logic [95:0]  srdata3;
  logic [2:0]   sready3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_bus_fabric #(.ADDR_W(10), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(16)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req4), .i_m_write(wr), .i_m_addr(addr),
    .i_m_width(width), .i_m_wdata(wdata), .o_m_rdata(rdata4), .o_m_ready(ready4),
    .o_m_err(err4), .o_s_sel(sel4), .o_s_write(swrite4), .o_s_addr(saddr4),
    .o_s_width(swidth4), .o_s_wdata(swdata4), .i_s_rdata(srdata4), .i_s_ready(sready4)
  );

  mmio_bus_fabric #(.ADDR_W(10), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(16)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req3), .i_m_write(wr), .i_m_addr(addr),
    .i_m_width(width), .i_m_wdata(wdata), .o_m_rdata(rdata3), .o_m_ready(ready3),
    .o_m_err(err3), .o_s_sel(sel3), .o_s_write(swrite3), .o_s_addr(saddr3),
    .o_s_width(swidth3), .o_s_wdata(swdata3), .i_s_rdata(srdata3), .i_s_ready(sready3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req4 = 1'b1; req3 = 1'b0; wr = 1'b0; addr = 10'h108;
    width = 4'hF; wdata = '0; srdata4 = '0; sready4 = '1; srdata3 = '0; sready3 = '0;
    tick; tick;
    checks++;
    if ({ready4, err4, rdata4, sel4, swrite4} !== 39'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl4: got ready=%b err=%b rdata=%h sel=%b write=%b, expected all 0",
               ready4, err4, rdata4, sel4, swrite4);
    end
    checks++;
    if ({saddr4, swidth4, swdata4} !== 46'd0) begin
      errors++;
      $display("[TB] FAIL reset_data4: got addr=%h width=%h wdata=%h, expected all 0",
               saddr4, swidth4, swdata4);
    end
    checks++;
    if ({ready3, err3, rdata3, sel3, swrite3, saddr3, swidth3, swdata3} !== 84'd0) begin
      errors++;
      $display("[TB] FAIL reset_all3: got ready=%b err=%b rdata=%h sel=%b addr=%h, expected all 0",
               ready3, err3, rdata3, sel3, saddr3);
    end
    req4 = 1'b0; sready4 = '0; rst_n = 1'b1;
    tick;
  endtask

  task automatic test_read;
    req4 = 1'b1; wr = 1'b0; addr = 10'h108; width = 4'hF;
    tick;
    req4 = 1'b0;
    checks++;
    if (sel4 !== 4'b0010) begin errors++; $display("[TB] FAIL read_sel: got %b, expected 0010", sel4); end
    checks++;
    if (saddr4 !== 10'h008) begin errors++; $display("[TB] FAIL read_saddr: got %h, expected 008", saddr4); end
    checks++;
    if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL read_early: got ready %b, expected 0", ready4); end
    srdata4[63:32] = 32'hDEADBEEF; sready4 = 4'b0010;
    tick;
    sready4 = '0;
    checks++;
    if ({ready4, err4} !== 2'b10) begin
      errors++; $display("[TB] FAIL read_resp: got ready/err %b%b, expected 10", ready4, err4);
    end
    checks++;
    if (rdata4 !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL read_data: got %h, expected deadbeef", rdata4);
    end
    checks++;
    if (sel4 !== 4'b0000) begin errors++; $display("[TB] FAIL read_sel_resp: got %b, expected 0000", sel4); end
    tick;
    checks++;
    if (ready4 !== 1'b0 || rdata4 !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL read_hold: got ready %b rdata %h, expected 0 deadbeef", ready4, rdata4);
    end
  endtask

  task automatic test_write;
    int wcycles = 0;
    req4 = 1'b1; wr = 1'b1; addr = 10'h300; width = 4'b0001; wdata = 32'h0000_00A5;
    srdata4[127:96] = 32'hFFFF_FFFF;
    tick;
    req4 = 1'b0; wr = 1'b0; width = 4'hF; wdata = 32'h1234_5678;
    for (int k = 1; k <= 4; k++) begin
      if (swrite4 === 1'b1) wcycles++;
      if (k == 1) begin
        checks++;
        if ({sel4, saddr4, swidth4, swdata4} !== {4'b1000, 10'h000, 4'b0001, 32'h0000_00A5}) begin
          errors++;
          $display("[TB] FAIL write_bus: got sel=%b addr=%h width=%b wdata=%h, expected 1000 000 0001 000000a5",
                   sel4, saddr4, swidth4, swdata4);
        end
      end
      if (k == 4) sready4 = 4'b1000;
      tick;
    end
    sready4 = '0;
    checks++;
    if (wcycles != 4) begin errors++; $display("[TB] FAIL write_cycles: got %0d, expected 4", wcycles); end
    checks++;
    if ({ready4, err4, swrite4} !== 3'b100 || rdata4 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL write_resp: got ready=%b err=%b write=%b rdata=%h, expected 1 0 0 00000000",
               ready4, err4, swrite4, rdata4);
    end
    tick;
  endtask

  task automatic test_decode_error;
    req3 = 1'b1; wr = 1'b0; addr = 10'h204;
    tick;
    req3 = 1'b0;
    checks++;
    if (sel3 !== 3'b100 || saddr3 !== 10'h004) begin
      errors++; $display("[TB] FAIL dec_good_sel: got sel %b addr %h, expected 100 004", sel3, saddr3);
    end
    srdata3[95:64] = 32'h1234_5678; sready3 = 3'b100;
    tick;
    sready3 = '0;
    checks++;
    if ({ready3, err3} !== 2'b10 || rdata3 !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL dec_good_resp: got ready=%b err=%b rdata=%h, expected 1 0 12345678",
                         ready3, err3, rdata3);
    end
    tick;
    req3 = 1'b1; addr = 10'h3F0;
    tick;
    req3 = 1'b0;
    checks++;
    if ({ready3, err3, sel3} !== 5'b11000 || rdata3 !== 32'd0) begin
      errors++; $display("[TB] FAIL dec_err_resp: got ready=%b err=%b sel=%b rdata=%h, expected 1 1 000 00000000",
                         ready3, err3, sel3, rdata3);
    end
    tick;
    checks++;
    if ({ready3, err3, sel3} !== 5'b00000) begin
      errors++; $display("[TB] FAIL dec_err_after: got ready=%b err=%b sel=%b, expected 0 0 000", ready3, err3, sel3);
    end
  endtask

  task automatic test_ready_filter;
    srdata4[31:0] = 32'hC0FF_EE00; srdata4[95:64] = 32'hBAD2_2222;
    req4 = 1'b1; wr = 1'b0; addr = 10'h010; sready4 = 4'b0100;
    tick;
    req4 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL filter_early k=%0d: got ready %b, expected 0", k, ready4); end
      if (k == 5) sready4 = 4'b0101;
      tick;
    end
    sready4 = '0;
    checks++;
    if ({ready4, err4} !== 2'b10 || rdata4 !== 32'hC0FF_EE00) begin
      errors++; $display("[TB] FAIL filter_resp: got ready=%b err=%b rdata=%h, expected 1 0 c0ffee00",
                         ready4, err4, rdata4);
    end
    tick;
  endtask

  task automatic test_timeout;
    int cnt = 0;
    bit done = 1'b0;
    req4 = 1'b1; wr = 1'b0; addr = 10'h020;
    tick;
    req4 = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (ready4 === 1'b1) done = 1'b1;
      else begin
        if (sel4 === 4'b0001) cnt++;
        tick;
      end
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL timeout_bound: got no ready in 40 cycles, expected ready"); end
    checks++;
    if (cnt != 16) begin errors++; $display("[TB] FAIL timeout_sel_cycles: got %0d, expected 16", cnt); end
    checks++;
    if (err4 !== 1'b1 || rdata4 !== 32'd0) begin
      errors++; $display("[TB] FAIL timeout_resp: got err=%b rdata=%h, expected 1 00000000", err4, rdata4);
    end
    tick;
    req4 = 1'b1; addr = 10'h108;
    tick;
    req4 = 1'b0;
    checks++;
    if (sel4 !== 4'b0010 || ready4 !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_idle: got sel %b ready %b, expected 0010 0", sel4, ready4);
    end
    sready4 = 4'b0010;
    tick;
    sready4 = '0;
    tick;
  endtask

  task automatic test_timeout_boundary;
    req4 = 1'b1; wr = 1'b0; addr = 10'h000;
    tick;
    req4 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL bound_early k=%0d: got ready %b, expected 0", k, ready4); end
      if (k == 16) sready4 = 4'b0001;
      tick;
    end
    sready4 = '0;
    checks++;
    if ({ready4, err4} !== 2'b10 || rdata4 !== 32'hC0FF_EE00) begin
      errors++; $display("[TB] FAIL bound_resp: got ready=%b err=%b rdata=%h, expected 1 0 c0ffee00",
                         ready4, err4, rdata4);
    end
    tick;
  endtask

  task automatic test_reset_abort;
    req4 = 1'b1; wr = 1'b1; addr = 10'h104; width = 4'b0011; wdata = 32'h55;
    tick;
    req4 = 1'b0; wr = 1'b0;
    checks++;
    if (sel4 !== 4'b0010 || swrite4 !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_access: got sel %b write %b, expected 0010 1", sel4, swrite4);
    end
    rst_n = 1'b0;
    tick;
    checks++;
    if ({ready4, err4, sel4, swrite4} !== 7'd0 || rdata4 !== 32'd0) begin
      errors++; $display("[TB] FAIL abort_ctrl: got ready=%b err=%b sel=%b write=%b rdata=%h, expected all 0",
                         ready4, err4, sel4, swrite4, rdata4);
    end
    checks++;
    if ({saddr4, swidth4, swdata4} !== 46'd0) begin
      errors++; $display("[TB] FAIL abort_data: got addr=%h width=%h wdata=%h, expected all 0", saddr4, swidth4, swdata4);
    end
    rst_n = 1'b1; sready4 = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (ready4 !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ready k=%0d: got %b, expected 0", k, ready4); end
    end
    sready4 = '0;
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    req4 = 1'b1; wr = 1'b0; addr = 10'h10C; sready4 = 4'b0010;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (ready4 === 1'b1) pulses++;
      checks++;
      if (ready4 !== ((i % 3) == 2)) begin
        errors++; $display("[TB] FAIL b2b_ready i=%0d: got %b, expected %b", i, ready4, (i % 3) == 2);
      end
    end
    req4 = 1'b0; sready4 = '0;
    checks++;
    if (pulses != 4) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d, expected 4", pulses); end
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_decode_error;
    test_ready_filter;
    test_timeout;
    test_timeout_boundary;
    test_reset_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
